// File: rtl/riscV_unrn_pkg.sv
// riscV_unrn_pkg: shared definitions for the decode stage.
//   - opcode constants (RV32I major opcodes)
//   - instr_type_t : instruction format classification
//   - dec_rec_t    : decoded instruction record stored in the decode queue
package riscV_unrn_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // TYPE_NONE is zero so a reset record reads as all-zero.
    typedef enum logic [2:0] {
        TYPE_NONE = 3'd0,
        TYPE_R    = 3'd1,
        TYPE_I    = 3'd2,
        TYPE_S    = 3'd3,
        TYPE_B    = 3'd4,
        TYPE_U    = 3'd5,
        TYPE_J    = 3'd6
    } instr_type_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        instr_type_t instr_type;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
    } dec_rec_t;

endpackage

// File: rtl/rv_decoder.sv
// rv_decoder: purely combinational RV32I(+M) instruction decoder.
//   instr : raw 32-bit instruction
//   pc    : PC of instr, copied into the record
//   dec   : decoded record (fields not used by the format are 0)
// Build option: DECODE_QUEUE_RV32M_EN makes funct7=0000001 R-type ops legal.
module rv_decoder
    import riscV_unrn_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output dec_rec_t    dec
);

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec        = '0;
        dec.pc     = pc;
        dec.opcode = instr[6:0];

        // Classify and check legality; field extraction follows per format.
        case (instr[6:0])
            OP_LOAD: begin
                dec.instr_type = TYPE_I;
                dec.illegal    = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OP_FENCE, OP_JALR, OP_SYSTEM: dec.instr_type = TYPE_I;
            OP_IMM: begin
                dec.instr_type = TYPE_I;
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (f3 == 3'b001) begin
                    dec.funct7  = f7;
                    dec.illegal = (f7 != F7_BASE);
                end else if (f3 == 3'b101) begin
                    dec.funct7  = f7;
                    dec.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
                end
            end
            OP_STORE: begin
                dec.instr_type = TYPE_S;
                dec.illegal    = (f3 > 3'b010);
            end
            OP_BRANCH: begin
                dec.instr_type = TYPE_B;
                dec.illegal    = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LUI, OP_AUIPC: dec.instr_type = TYPE_U;
            OP_JAL:           dec.instr_type = TYPE_J;
            OP_REG: begin
                dec.instr_type = TYPE_R;
                case (f7)
                    F7_BASE:   dec.illegal = 1'b0;
                    F7_ALT:    dec.illegal = !((f3 == 3'b000) || (f3 == 3'b101));
`ifdef DECODE_QUEUE_RV32M_EN
                    F7_MULDIV: dec.illegal = 1'b0;
`else
                    F7_MULDIV: dec.illegal = 1'b1;
`endif
                    default:   dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase

        if (instr[1:0] != 2'b11)
            dec.illegal = 1'b1;

        case (dec.instr_type)
            TYPE_R: begin
                dec.rd     = instr[11:7];
                dec.rs1    = instr[19:15];
                dec.rs2    = instr[24:20];
                dec.funct3 = f3;
                dec.funct7 = f7;
            end
            TYPE_I: begin
                dec.rd     = instr[11:7];
                dec.rs1    = instr[19:15];
                dec.funct3 = f3;
                dec.imm    = imm_i;
            end
            TYPE_S: begin
                dec.rs1    = instr[19:15];
                dec.rs2    = instr[24:20];
                dec.funct3 = f3;
                dec.imm    = imm_s;
            end
            TYPE_B: begin
                dec.rs1    = instr[19:15];
                dec.rs2    = instr[24:20];
                dec.funct3 = f3;
                dec.imm    = imm_b;
            end
            TYPE_U: begin
                dec.rd  = instr[11:7];
                dec.imm = imm_u;
            end
            TYPE_J: begin
                dec.rd  = instr[11:7];
                dec.imm = imm_j;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: decode stage buffering decoded instructions in a DEPTH-entry FIFO.
//   clk, rst_n           : clock, synchronous active-low reset
//   flush_i              : discard all queued entries
//   in_valid_i/in_ready_o: fetch handshake; in_instr_i, in_pc_i raw instruction + PC
//   out_valid_o/out_ready_i: execute handshake; out_dec_o head record (dec_rec_t)
//   count_o              : current occupancy
// Build option: DECODE_QUEUE_RV32M_EN (see rv_decoder) enables RV32M decode.
module decode_queue
    import riscV_unrn_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [31:0]                  in_instr_i,
    input  logic [31:0]                  in_pc_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [$bits(dec_rec_t)-1:0]  out_dec_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    dec_rec_t           in_dec;
    dec_rec_t           mem [DEPTH];
    dec_rec_t           head_q, head_nx;
    logic [PTR_W-1:0]   rptr_q, wptr_q, rptr_nx, wptr_nx;
    logic [CNT_W-1:0]   count_q, count_nx;
    logic               ready_q;
    logic               do_push, do_pop;

    rv_decoder u_dec (
        .instr (in_instr_i),
        .pc    (in_pc_i),
        .dec   (in_dec)
    );

    always_comb begin
        do_push = in_valid_i && ready_q && !flush_i;
        do_pop  = (count_q != '0) && out_ready_i;

        if (flush_i) begin
            rptr_nx  = '0;
            wptr_nx  = '0;
            count_nx = '0;
        end else begin
            rptr_nx  = rptr_q + PTR_W'(do_pop);
            wptr_nx  = wptr_q + PTR_W'(do_push);
            count_nx = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end

        // Head is registered so it can hold its last value when empty; when the
        // new head is the slot being written this cycle, take the incoming record.
        head_nx = head_q;
        if (count_nx != '0)
            head_nx = (do_push && (wptr_q == rptr_nx)) ? in_dec : mem[rptr_nx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            head_q  <= '0;
        end else begin
            rptr_q  <= rptr_nx;
            wptr_q  <= wptr_nx;
            count_q <= count_nx;
            ready_q <= (count_nx != CNT_W'(DEPTH));
            head_q  <= head_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push)
            mem[wptr_q] <= in_dec;
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (count_q != '0);
    assign out_dec_o   = head_q;
    assign count_o     = count_q;

endmodule
